// File: rtl/mem_responder.sv
// Single-ported word RAM that serves instruction fetches and data reads/writes with a fixed read latency.
// Optional MEM_RESP_BOUNDS_CHECK_EN adds a sticky err output for addresses beyond the RAM.
module mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_start,
  output logic        inst_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic [2:0]  d_cmd,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] wdata,
  input  logic [31:0] wmask,
  output logic [31:0] rdata,
  output logic        rdata_valid
`ifdef MEM_RESP_BOUNDS_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, IBUSY, DRD, DWR} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    oob_q;
  logic [31:0]             inst_q, rdata_q;
  logic                    inst_valid_q, rdata_valid_q;
  logic [31:0]             mem_q [DEPTH];

  logic                    is_rd, is_wr, idle;
  logic                    if_acc, rd_acc, wr_acc;
  logic [ADDR_WIDTH-1:0]   i_idx, d_idx, rd_idx;
  logic                    i_oob, d_oob, rd_oob;
  logic [31:0]             rd_word;
  logic                    unused_addr_bits;

  assign is_rd = (d_cmd == 3'd1);
  assign is_wr = (d_cmd == 3'd2);
  assign idle  = (state_q == IDLE);

  assign d_cmd_ready = rst_n & idle;
  assign inst_ready  = rst_n & idle & ~(is_rd | is_wr);

  assign rd_acc = is_rd & d_cmd_ready;
  assign wr_acc = is_wr & d_cmd_ready;
  assign if_acc = inst_start & inst_ready;

  assign i_idx = i_addr[ADDR_WIDTH+1:2];
  assign d_idx = d_addr[ADDR_WIDTH+1:2];

  // Byte offset is ignored; high bits only matter when bounds checking is built in.
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0],
                              i_addr[31:ADDR_WIDTH+2], d_addr[31:ADDR_WIDTH+2]};

`ifdef MEM_RESP_BOUNDS_CHECK_EN
  assign i_oob = |i_addr[31:ADDR_WIDTH+2];
  assign d_oob = |d_addr[31:ADDR_WIDTH+2];
`else
  assign i_oob = 1'b0;
  assign d_oob = 1'b0;
`endif

  // With LATENCY==1 the word is captured on the acceptance edge, otherwise from the latched index.
  always_comb begin
    if (LATENCY == 1) begin
      rd_idx = rd_acc ? d_idx : i_idx;
      rd_oob = rd_acc ? d_oob : i_oob;
    end else begin
      rd_idx = addr_q;
      rd_oob = oob_q;
    end
    rd_word = rd_oob ? 32'h0 : mem_q[rd_idx];
  end

  // RAM contents survive reset; writes land on the acceptance edge.
  always_ff @(posedge clk) begin
    if (wr_acc && !d_oob)
      mem_q[d_idx] <= (mem_q[d_idx] & ~wmask) | (wdata & wmask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      oob_q         <= 1'b0;
      inst_q        <= '0;
      rdata_q       <= '0;
      inst_valid_q  <= 1'b0;
      rdata_valid_q <= 1'b0;
    end else begin
      inst_valid_q  <= 1'b0;
      rdata_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_acc || wr_acc) begin
            addr_q <= d_idx;
            oob_q  <= d_oob;
            if (wr_acc) begin
              state_q <= DWR;
            end else if (LATENCY == 1) begin
              rdata_q       <= rd_word;
              rdata_valid_q <= 1'b1;
            end else begin
              state_q <= DRD;
              cnt_q   <= CNT_INIT;
            end
          end else if (if_acc) begin
            addr_q <= i_idx;
            oob_q  <= i_oob;
            if (LATENCY == 1) begin
              inst_q       <= rd_word;
              inst_valid_q <= 1'b1;
            end else begin
              state_q <= IBUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        IBUSY, DRD: begin
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            if (state_q == IBUSY) begin
              inst_q       <= rd_word;
              inst_valid_q <= 1'b1;
            end else begin
              rdata_q       <= rd_word;
              rdata_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DWR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_RESP_BOUNDS_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (((rd_acc || wr_acc) && d_oob) || (if_acc && !(rd_acc || wr_acc) && i_oob))
      err_q <= 1'b1;
  end
  assign err = err_q;
`endif

  assign inst        = inst_q;
  assign inst_valid  = inst_valid_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: word-address bits; RAM depth 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter LATENCY, default 2: read latency in cycles; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 inst_start  input  1  instruction-fetch request.
REQ-006 inst_ready  output  1  fetch request may be accepted this cycle.
REQ-007 i_addr  input  32  fetch byte address.
REQ-008 inst  output  32  fetched word.
REQ-009 inst_valid  output  1  inst is valid this cycle.
REQ-010 d_cmd  input  3  data command: 0 = none, 1 = read, 2 = write, others = none.
REQ-011 d_cmd_ready  output  1  data command may be accepted this cycle.
REQ-012 d_addr  input  32  data byte address.
REQ-013 wdata  input  32  write data.
REQ-014 wmask  input  32  per-bit write enable.
REQ-015 rdata  output  32  read data.
REQ-016 rdata_valid  output  1  rdata is valid this cycle.

Function
REQ-017 The RAM is single-ported and indexed by addr[ADDR_WIDTH+1:2]; addr[1:0] and any bits above ADDR_WIDTH+1 are ignored, so out-of-range addresses wrap.
REQ-018 States: IDLE, IBUSY, DRD, DWR.
REQ-019 inst_ready = rst_n & IDLE & (d_cmd not 1 or 2); d_cmd_ready = rst_n & IDLE.
REQ-020 Fetch acceptance: inst_start & inst_ready at a rising edge; transition IDLE->IBUSY; i_addr is latched.
REQ-021 Data read acceptance: d_cmd==1 & d_cmd_ready; transition IDLE->DRD; d_addr is latched.
REQ-022 Data write acceptance: d_cmd==2 & d_cmd_ready; at that edge mem = (mem & ~wmask) | (wdata & wmask); transition IDLE->DWR; DWR->IDLE after one cycle.
REQ-023 Simultaneous fetch and data requests in IDLE: the data request wins; the fetch stays pending and is accepted at a later IDLE cycle.
REQ-024 Read latency: valid is high for exactly one cycle, LATENCY cycles after the acceptance cycle (LATENCY=1 means the next cycle).
REQ-025 The state returns to IDLE in the cycle in which valid is high, so readies are high in that cycle and a back-to-back request can be accepted there.
REQ-026 inst and rdata hold their last value until the next completion of the same port.
REQ-027 A read accepted after a write observes the written data (no stale read).
REQ-028 No request is queued: a request not accepted leaves no side effect.

Reset
REQ-029 While rst_n is low: state IDLE, latency counter 0, inst 0, rdata 0, inst_valid 0, rdata_valid 0, inst_ready 0, d_cmd_ready 0.
REQ-030 Asserting rst_n mid-transaction aborts the transaction: no valid pulse occurs afterward.
REQ-031 Reset does not clear RAM contents; a write whose acceptance edge completed before reset assertion persists.

Configuration
REQ-032 Macro MEM_RESP_BOUNDS_CHECK_EN defined: the block adds output err (1 bit, reset 0, sticky until reset). err is set on acceptance of any address with nonzero bits above ADDR_WIDTH+1. Such a write is dropped. Such a read completes with data 0 and normal latency.
REQ-033 Macro MEM_RESP_BOUNDS_CHECK_EN undefined: the err port does not exist, and addresses wrap per REQ-017.

Verification
REQ-034 LATENCY=2, preload word 0x10 = 0xDEADBEEF; inst_start=1, i_addr=0x40 -> inst_valid high exactly 2 cycles after acceptance, inst=0xDEADBEEF, inst_ready low in between.
REQ-035 Write d_addr=0x8, wdata=0xAAAA5555, wmask=0x0000FFFF over existing 0x12345678, then read 0x8 -> rdata=0x12345555.
REQ-036 Same cycle in IDLE: inst_start=1 and d_cmd=1 -> data read accepted first (inst_ready=0 that cycle), fetch accepted on the rdata_valid cycle, inst_valid follows LATENCY cycles later.
REQ-037 ADDR_WIDTH=12, write 0x1 to 0x4004, read 0x0004 -> rdata=0x1 (wrap). With MEM_RESP_BOUNDS_CHECK_EN the write is dropped, err=1, and a read of 0x4004 returns 0.
REQ-038 Assert rst_n=0 one cycle after read acceptance, release it -> no rdata_valid pulse, readies are high after release, and RAM contents are unchanged.
REQ-039 LATENCY=1 with back-to-back fetches of 0x0, 0x4, 0x8 -> inst_valid pulses on 3 consecutive completions, each accepted in the previous completion cycle.
